servo_cmd_sequencer: RTL and testbench
======================================

# servo_cmd_sequencer

Queued command sequencer that drives the 2-bit `dir` input of the servo PWM block. It accepts timed motion commands (direction plus duration) over a valid/ready handshake and buffers them in a small FIFO. It plays the commands back in order, holding each direction for an exact number of millisecond ticks. A STOP dead-time is inserted automatically whenever the drive direction reverses, so the servo never flips directly between POS and NEG.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of 2, ≥2.
- `TICK_DIV`, 100_000: clk cycles per duration tick (1 ms at 100 MHz).
- `DUR_W`, 16: width of the duration field.
- `DEAD_TICKS`, 20: STOP ticks inserted on reversal; 0 disables the dead-time.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: FIFO can accept a command.
- `cmd_dir` input 2: 00 stop, 01 and 10 drive, 11 treated as stop.
- `cmd_dur` input DUR_W: hold time in ticks.
- `dir` output 2: registered; goes to the servo block's `dir`.
- `busy` output 1: a command is running, in dead-time, or queued.
- `cmd_done` output 1: one-cycle pulse when a command's RUN completes.
- `level` output $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Accept a command when `cmd_valid && cmd_ready` at a posedge. `cmd_ready = !full && !rst`.
- Push and pop in the same cycle are both performed; `level` is unchanged.
- When full, a push is not accepted. The command is held by the sender.
- States:
  - IDLE: `dir` = 00.
  - DEAD: `dir` = 00; counts `DEAD_TICKS` ticks.
  - RUN: `dir` = the current command's direction, with 11 normalised to 00.
- The prescaler resets to 0 on every state entry. It asserts `tick` when it reaches `TICK_DIV-1`, then wraps to 0. A tick counter counts ticks within the state.
- `last_dir` holds the most recent non-stop direction that was run. It resets to 00.
- Dispatch happens from IDLE, or at the end of RUN/DEAD, whenever the FIFO is non-empty:
  - Pop the head command.
  - If the head direction is nonzero and opposite to `last_dir`, and `DEAD_TICKS` > 0, go to DEAD. The command is held pending.
  - Otherwise go to RUN.
- DEAD completes after `DEAD_TICKS` ticks. It then enters RUN with the pending command and does not pop again.
- RUN lasts `cmd_dur × TICK_DIV` cycles. `cmd_dur` = 0 gives a RUN of exactly 1 cycle.
- At the end of RUN:
  - Pulse `cmd_done`.
  - Update `last_dir` if the command was nonzero.
  - Dispatch the next command, or go to IDLE if the FIFO is empty.
- In IDLE, the prescaler runs. After `DEAD_TICKS` ticks of continuous IDLE, `last_dir` clears to 00, so no dead-time is needed on restart.
- A stop command (00/11) does not change `last_dir`. It does not count as dead-time.
- `busy = (state != IDLE) || (level != 0)`.

## Timing
- Reset values: `dir` = 00, `cmd_done` = 0, `busy` = 0, `level` = 0, `cmd_ready` = 0 while `rst` is high.
- Reset also sets state to IDLE, empties the FIFO and zeroes all counters.
- `rst` asserted mid-command aborts the command. `dir` is 00 at the next edge and no `cmd_done` is issued.
- Latency: a command accepted at edge N into an empty FIFO while IDLE is popped at edge N+1. `dir` shows the new direction after edge N+1.
- Back-to-back commands in the same direction: `dir` changes at the same edge where `cmd_done` rises, with no STOP gap.
- With reversal, after `cmd_done` the output is `dir` = 00 for `DEAD_TICKS × TICK_DIV` cycles, then the new direction.
- `cmd_ready` is derived from the registered `level`. A pop in the current cycle does not raise `cmd_ready` until the next cycle.

## Configuration
- `SERVO_SEQ_ESTOP_EN` defined:
  - Adds input `estop` (1 bit).
  - While `estop` is high: `dir` = 00, the FIFO is flushed, `cmd_ready` = 0, state is forced to IDLE, and the running command is aborted without `cmd_done`.
  - `last_dir` is retained, so the reversal rule still applies after release.
  - `estop` has priority below `rst` and above all other inputs.
- Not defined: there is no `estop` port and no flush path.

## Test plan
All scenarios use `TICK_DIV`=4, `DEAD_TICKS`=2, `DEPTH`=4.
- Reset, then push {01, dur 3}: `dir` = 01 one cycle after acceptance, held 12 cycles. `cmd_done` pulses once, then `dir` = 00 and `busy` = 0.
- Push {01,2} then {10,1}: `dir` sequence is 01 for 8 cycles, then 00 for 8 cycles, then 10 for 4 cycles. There are two `cmd_done` pulses.
- Push {01,1} then {01,1}: `dir` = 01 for 8 continuous cycles with no 00 gap. `cmd_done` pulses at cycles 4 and 8.
- Hold `cmd_valid` high with 6 commands while RUN is stalled on a long duration: `level` reaches 4, `cmd_ready` = 0, no command is lost or duplicated, and the order is preserved.
- Push {10,0}, then {11,2}: `dir` = 10 for 1 cycle, then 00 for 8 cycles. `last_dir` = 10.
- Assert `rst` mid-RUN (and `estop` with `SERVO_SEQ_ESTOP_EN`): `dir` = 00 at the next edge, `level` = 0, no `cmd_done`.

Source files
------------

// File: rtl/servo_cmd_sequencer.sv
// rtl/servo_cmd_sequencer.sv - queued timed direction sequencer for the servo PWM block
// Optional emergency stop input is enabled by defining SERVO_SEQ_ESTOP_EN.
module servo_cmd_sequencer #(
    parameter int DEPTH      = 4,
    parameter int TICK_DIV   = 100_000,
    parameter int DUR_W      = 16,
    parameter int DEAD_TICKS = 20
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef SERVO_SEQ_ESTOP_EN
    input  logic                     estop,
`endif
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_dir,
    input  logic [DUR_W-1:0]         cmd_dur,
    output logic [1:0]               dir,
    output logic                     busy,
    output logic                     cmd_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DTW = $clog2(DEAD_TICKS + 2);
    localparam int CW  = (DUR_W > DTW) ? DUR_W : DTW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_mem_dir [DEPTH];
    logic [DUR_W-1:0]   r_mem_dur [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;

    logic [PW-1:0]      r_pre;
    logic [CW-1:0]      r_ticks;
    logic [1:0]         r_cur_dir;
    logic [DUR_W-1:0]   r_cur_dur;
    logic [1:0]         r_last_dir;
    logic [1:0]         r_dir;
    logic               r_done;

    logic               w_stop;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_tick;
    logic               w_enter;
    logic               w_run_end;
    logic               w_dispatch;
    logic               w_go_dead;
    logic [1:0]         w_last_eff;
    logic [1:0]         w_in_dir;
    logic [1:0]         w_head_dir;
    logic [DUR_W-1:0]   w_head_dur;
    logic [CW-1:0]      w_ticks_inc;

`ifdef SERVO_SEQ_ESTOP_EN
    assign w_stop = estop;
`else
    assign w_stop = 1'b0;
`endif

    assign w_full      = (r_level == LW'(DEPTH));
    assign w_empty     = (r_level == '0);
    assign cmd_ready   = !w_full && !rst && !w_stop;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_in_dir    = (cmd_dir == 2'b11) ? 2'b00 : cmd_dir;
    assign w_head_dir  = r_mem_dir[r_rd_ptr];
    assign w_head_dur  = r_mem_dur[r_rd_ptr];
    assign w_tick      = (r_pre == PW'(TICK_DIV - 1));
    assign w_ticks_inc = r_ticks + CW'(1);

    assign dir      = r_dir;
    assign cmd_done = r_done;
    assign level    = r_level;
    assign busy     = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge clk) begin
        if (rst || w_stop) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The reversal test uses last_dir as it will be after this edge, so a
    // finishing RUN or an expiring idle period is already taken into account.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_enter     = 1'b0;
        w_run_end   = 1'b0;
        w_dispatch  = 1'b0;
        w_go_dead   = 1'b0;
        w_last_eff  = r_last_dir;
        unique case (r_state)
            S_IDLE: begin
                if (w_tick && (w_ticks_inc == CW'(DEAD_TICKS))) begin
                    w_last_eff = 2'b00;
                end
                w_dispatch = !w_empty;
            end
            S_DEAD: begin
                if (w_tick && (w_ticks_inc == CW'(DEAD_TICKS))) begin
                    w_state_nxt = S_RUN;
                    w_enter     = 1'b1;
                end
            end
            S_RUN: begin
                w_run_end = (r_cur_dur == '0) ||
                            (w_tick && (w_ticks_inc == CW'(r_cur_dur)));
                if (w_run_end) begin
                    if (r_cur_dir != 2'b00) begin
                        w_last_eff = r_cur_dir;
                    end
                    w_dispatch = !w_empty;
                    if (w_empty) begin
                        w_state_nxt = S_IDLE;
                        w_enter     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_enter     = 1'b1;
            end
        endcase
        if (w_dispatch) begin
            w_pop       = 1'b1;
            w_enter     = 1'b1;
            w_go_dead   = (DEAD_TICKS > 0) && (w_head_dir != 2'b00) &&
                          (w_last_eff != 2'b00) && (w_head_dir != w_last_eff);
            w_state_nxt = w_go_dead ? S_DEAD : S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dir[r_wr_ptr] <= w_in_dir;
            r_mem_dur[r_wr_ptr] <= cmd_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_pre      <= '0;
            r_ticks    <= '0;
            r_cur_dir  <= 2'b00;
            r_cur_dur  <= '0;
            r_last_dir <= 2'b00;
            r_dir      <= 2'b00;
            r_done     <= 1'b0;
        end else if (w_stop) begin
            // Flush and abort, but keep last_dir so a reversal still gets dead-time.
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_pre     <= '0;
            r_ticks   <= '0;
            r_cur_dir <= 2'b00;
            r_cur_dur <= '0;
            r_dir     <= 2'b00;
            r_done    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_cur_dir <= w_head_dir;
                r_cur_dur <= w_head_dur;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            r_done     <= w_run_end;
            r_last_dir <= w_last_eff;

            if (w_enter) begin
                r_pre   <= '0;
                r_ticks <= '0;
            end else begin
                r_pre <= w_tick ? '0 : r_pre + PW'(1);
                if (w_tick && ((r_state != S_IDLE) || (r_ticks != CW'(DEAD_TICKS)))) begin
                    r_ticks <= w_ticks_inc;
                end
            end

            if (w_state_nxt == S_RUN) begin
                r_dir <= w_pop ? w_head_dir : r_cur_dir;
            end else begin
                r_dir <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// tb/tb_servo_cmd_sequencer.sv - randomized self-checking bench for servo_cmd_sequencer
module tb_servo_cmd_sequencer;

    localparam int DEPTH      = 4;
    localparam int TICK_DIV   = 4;
    localparam int DEAD_TICKS = 2;
    localparam int DUR_W      = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_dir;
    logic [DUR_W-1:0]   cmd_dur;
    logic [1:0]         dir;
    logic               busy;
    logic               cmd_done;
    logic [2:0]         level;
`ifdef SERVO_SEQ_ESTOP_EN
    logic               estop = 1'b0;
`endif

    always #5 clk = ~clk;

    servo_cmd_sequencer #(
        .DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .DUR_W(DUR_W), .DEAD_TICKS(DEAD_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef SERVO_SEQ_ESTOP_EN
        .estop(estop),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_dur(cmd_dur),
        .dir(dir),
        .busy(busy),
        .cmd_done(cmd_done),
        .level(level)
    );

    typedef struct {
        logic [1:0] d;
        int         dur;
    } cmd_t;

    cmd_t q[$];
    int   m_state;   // 0 idle, 1 dead-time, 2 running
    int   m_rem;     // cycles left in the current dead/run period
    int   m_idle;    // cycles spent in the current idle period
    int   m_last;
    int   m_cur;
    int   m_cur_dur;
    int   m_done;
    int   m_dir;
    bit   m_acc;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] norm(input logic [1:0] d);
        return (d == 2'b11) ? 2'b00 : d;
    endfunction

    task automatic model_step();
        cmd_t h;
        bit   disp;
        m_done = 0;
        m_acc  = 0;
        if (rst) begin
            q.delete();
            m_state = 0; m_idle = 0; m_last = 0; m_cur = 0; m_dir = 0; m_rem = 0;
            return;
        end
        m_acc = cmd_valid && (q.size() < DEPTH);
        disp  = 0;
        if (m_state == 0) begin
            m_idle++;
            if (m_idle == DEAD_TICKS * TICK_DIV) m_last = 0;
            disp = (q.size() != 0);
        end else if (m_state == 1) begin
            m_rem--;
            if (m_rem == 0) begin
                m_state = 2;
                m_rem   = (m_cur_dur == 0) ? 1 : m_cur_dur * TICK_DIV;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1;
                if (m_cur != 0) m_last = m_cur;
                if (q.size() != 0) disp = 1;
                else begin
                    m_state = 0;
                    m_idle  = 0;
                end
            end
        end
        if (disp) begin
            h = q.pop_front();
            m_cur     = h.d;
            m_cur_dur = h.dur;
            if (DEAD_TICKS > 0 && h.d != 0 && m_last != 0 && h.d != m_last) begin
                m_state = 1;
                m_rem   = DEAD_TICKS * TICK_DIV;
            end else begin
                m_state = 2;
                m_rem   = (h.dur == 0) ? 1 : h.dur * TICK_DIV;
            end
        end
        if (m_acc) q.push_back('{d: norm(cmd_dir), dur: int'(cmd_dur)});
        m_dir = (m_state == 2) ? m_cur : 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("dir", {30'd0, dir}, m_dir);
        check("cmd_done", {31'd0, cmd_done}, m_done);
        check("level", {29'd0, level}, q.size());
        check("busy", {31'd0, busy}, (m_state != 0 || q.size() != 0) ? 1 : 0);
        check("cmd_ready", {31'd0, cmd_ready}, (!rst && q.size() < DEPTH) ? 1 : 0);
    endtask

    task automatic send(input logic [1:0] d, input int dur);
        int n;
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_dur   = DUR_W'(dur);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!m_acc && n < 400);
        if (!m_acc) check("send_timeout", 1, 0);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((m_state != 0 || q.size() != 0) && n < 1000);
        if (m_state != 0 || q.size() != 0) check("drain_timeout", 1, 0);
        repeat (3) cycle();
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 2'b00;
        cmd_dur   = '0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        send(2'b01, 3);
        drain();
        send(2'b01, 2);
        send(2'b10, 1);
        drain();
        send(2'b01, 1);
        send(2'b01, 1);
        drain();
        send(2'b01, 12);
        for (int i = 0; i < 6; i++) send(2'(i % 3), i % 3);
        drain();
        send(2'b10, 0);
        send(2'b11, 2);
        send(2'b01, 1);
        drain();
        send(2'b01, 5);
        repeat (6) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (4) cycle();

        for (int i = 0; i < 3000; i++) begin
            if (!cmd_valid || m_acc) begin
                cmd_valid = ($urandom_range(0, 2) != 0);
                cmd_dir   = 2'($urandom_range(0, 3));
                cmd_dur   = ($urandom_range(0, 9) == 0) ? DUR_W'(12) : DUR_W'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
